// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: WB has priority over the MDU, an MDU destination
// scoreboard drives DECODE hazards, and a starvation FSM requests a one-cycle WB stall.
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_rd,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_rd,
    input  logic [31:0] md_data,
    input  logic [4:0]  dec_rs,
    input  logic [4:0]  dec_rt,
    output logic        hazard_rs,
    output logic        hazard_rt,
    output logic        stall_wb,
    output logic        regwrite,
    output logic [4:0]  rd,
    output logic [31:0] writedata,
    output logic [1:0]  dbg_state,
    output logic [3:0]  dbg_wait_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FORCE = 2'd2
    } state_e;

    localparam logic [3:0] LAST_WAIT = 4'(STARVE_LIMIT - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        stall_q, stall_d;
    logic [31:0] pending_q, pending_d;
    logic        regwrite_q, regwrite_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] writedata_q, writedata_d;
    logic        md_xfer;

    // MDU handshake: md_valid may be held across cycles; a transfer happens on valid & ready.
    always_comb begin
        md_ready = md_valid & ~wb_regwrite & ~rst;
        md_xfer  = md_valid & md_ready;
    end

    always_comb begin
        regwrite_d  = 1'b0;
        rd_d        = rd_q;
        writedata_d = writedata_q;
        if (wb_regwrite) begin
            regwrite_d  = (wb_rd != 5'd0);
            rd_d        = wb_rd;
            writedata_d = wb_data;
        end else if (md_xfer) begin
            regwrite_d  = (md_rd != 5'd0);
            rd_d        = md_rd;
            writedata_d = md_data;
        end
    end

    // Set is applied after clear so a same-cycle issue to the same register wins.
    always_comb begin
        pending_d = pending_q;
        if (md_xfer) pending_d[md_rd] = 1'b0;
        if (md_issue) pending_d[md_issue_rd] = 1'b1;
        pending_d[0] = 1'b0;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!md_valid || md_xfer) begin
            state_d = S_IDLE;
            cnt_d   = 4'd0;
        end else if (state_q == S_FORCE) begin
            state_d = S_WAIT;
            cnt_d   = 4'd0;
        end else if (cnt_q == LAST_WAIT) begin
            state_d = S_FORCE;
            cnt_d   = 4'd0;
        end else begin
            state_d = S_WAIT;
            cnt_d   = cnt_q + 4'd1;
        end
        stall_d = (state_d == S_FORCE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            stall_q     <= 1'b0;
            pending_q   <= 32'd0;
            regwrite_q  <= 1'b0;
            rd_q        <= 5'd0;
            writedata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            stall_q     <= stall_d;
            pending_q   <= pending_d;
            regwrite_q  <= regwrite_d;
            rd_q        <= rd_d;
            writedata_q <= writedata_d;
        end
    end

    always_comb begin
        hazard_rs    = pending_q[dec_rs];
        hazard_rt    = pending_q[dec_rt];
        stall_wb     = stall_q;
        regwrite     = regwrite_q;
        rd           = rd_q;
        writedata    = writedata_q;
        dbg_state    = state_q;
        dbg_wait_cnt = cnt_q;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: directed scenarios with literal pins, then randomized
// traffic, all checked every cycle against a behavioural model of the write port.
module tb_regfile_wr_arbiter;

    localparam int STARVE_LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        md_issue;
    logic [4:0]  md_issue_rd;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_rd;
    logic [31:0] md_data;
    logic [4:0]  dec_rs;
    logic [4:0]  dec_rt;
    logic        hazard_rs;
    logic        hazard_rt;
    logic        stall_wb;
    logic        regwrite;
    logic [4:0]  rd;
    logic [31:0] writedata;
    logic [1:0]  dbg_state;
    logic [3:0]  dbg_wait_cnt;

    regfile_wr_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .rst(rst),
        .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
        .md_issue(md_issue), .md_issue_rd(md_issue_rd),
        .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
        .dec_rs(dec_rs), .dec_rt(dec_rt),
        .hazard_rs(hazard_rs), .hazard_rt(hazard_rt), .stall_wb(stall_wb),
        .regwrite(regwrite), .rd(rd), .writedata(writedata),
        .dbg_state(dbg_state), .dbg_wait_cnt(dbg_wait_cnt)
    );

    // Clock/reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Behavioural model: registers as a bit array, expected writes as a queue,
    // starvation as a run length of WB-blocked MDU cycles.
    bit            pend[32];
    bit            m_stall;
    int            run;
    bit            m_xfer;
    logic [36:0]   exp_q[$];

    always @(posedge clk) begin
        m_xfer = md_valid && !wb_regwrite && !rst;
        if (rst) begin
            foreach (pend[i]) pend[i] = 1'b0;
            m_stall = 1'b0;
            run     = 0;
            exp_q.delete();
        end else begin
            if (wb_regwrite) begin
                if (wb_rd != 0) exp_q.push_back({wb_rd, wb_data});
            end else if (m_xfer) begin
                if (md_rd != 0) exp_q.push_back({md_rd, md_data});
            end
            if (m_xfer) pend[md_rd] = 1'b0;
            if (md_issue && md_issue_rd != 0) pend[md_issue_rd] = 1'b1;
            if (m_stall) begin
                m_stall = 1'b0;
                run     = 0;
            end else if (md_valid && wb_regwrite) begin
                run++;
                if (run == STARVE_LIMIT) begin
                    m_stall = 1'b1;
                    run     = 0;
                end
            end else begin
                run = 0;
            end
        end
    end

    // Scoreboard compare, away from the active edge
    always @(negedge clk) begin
        logic [36:0] e;
        if (chk_en) begin
            check("md_ready", md_ready, (md_valid && !wb_regwrite && !rst));
            check("hazard_rs", hazard_rs, pend[dec_rs]);
            check("hazard_rt", hazard_rt, pend[dec_rt]);
            check("stall_wb", stall_wb, m_stall);
            check("regwrite", regwrite, exp_q.size() != 0);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (regwrite === 1'b1) begin
                    check("rd", rd, e[36:32]);
                    check("writedata", writedata, e[31:0]);
                end
            end
        end
    end

    task automatic quiet();
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0;
        md_issue = 1'b0; md_issue_rd = 5'd0;
        md_valid = 1'b0; md_rd = 5'd0; md_data = 32'd0;
        dec_rs = 5'd0; dec_rt = 5'd0;
    endtask

    initial begin
        int wb_pct;
        quiet();
        rst = 1'b1;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h0badf00d;

        // Reset held two cycles with md_valid high
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_md_ready", md_ready, 0);
        check("rst_regwrite", regwrite, 0);
        check("rst_stall", stall_wb, 0);
        check("rst_haz", {hazard_rs, hazard_rt}, 0);
        rst = 1'b0;
        quiet();
        tick();

        // Priority conflict
        wb_regwrite = 1'b1; wb_rd = 5'd5; wb_data = 32'h11111111;
        md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h22222222;
        #1 check("prio_blocked", md_ready, 0);
        tick();
        wb_regwrite = 1'b0;
        #1;
        check("prio_wb_rd", rd, 5);
        check("prio_wb_data", writedata, 32'h11111111);
        check("prio_md_ready", md_ready, 1);
        tick();
        md_valid = 1'b0;
        #1;
        check("prio_md_rd", rd, 6);
        check("prio_md_data", writedata, 32'h22222222);
        tick();

        // Starvation: WB writes continuously
        wb_regwrite = 1'b1; wb_rd = 5'd1; wb_data = 32'h00000aaa;
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h77777777;
        for (int i = 1; i <= STARVE_LIMIT; i++) begin
            #1 check("starve_no_stall", stall_wb, 0);
            tick();
        end
        wb_regwrite = 1'b0;
        #1;
        check("starve_stall", stall_wb, 1);
        check("starve_ready", md_ready, 1);
        check("starve_cnt_force", dbg_wait_cnt, 0);
        tick();
        md_valid = 1'b0;
        #1;
        check("starve_stall_drop", stall_wb, 0);
        check("starve_wr_rd", rd, 7);
        check("starve_state_idle", dbg_state, 0);
        check("starve_cnt_idle", dbg_wait_cnt, 0);
        tick();

        // Scoreboard: issue to 9, later transfer to 9
        md_issue = 1'b1; md_issue_rd = 5'd9; dec_rs = 5'd9; dec_rt = 5'd9;
        #1 check("sb_not_yet", hazard_rs, 0);
        tick();
        md_issue = 1'b0;
        #1;
        check("sb_haz_rs", hazard_rs, 1);
        check("sb_haz_rt", hazard_rt, 1);
        tick();
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99999999;
        #1 check("sb_haz_during_xfer", hazard_rs, 1);
        tick();
        md_valid = 1'b0;
        #1 check("sb_haz_cleared", hazard_rs, 0);
        md_issue = 1'b1; md_issue_rd = 5'd9;
        md_valid = 1'b1; md_rd = 5'd9; md_data = 32'h99990000;
        tick();
        md_issue = 1'b0; md_valid = 1'b0;
        #1 check("sb_set_wins", hazard_rt, 1);
        md_valid = 1'b1;
        tick();
        md_valid = 1'b0;
        #1 check("sb_final_clear", hazard_rt, 0);
        tick();

        // Register 0 writes are dropped
        quiet();
        wb_regwrite = 1'b1; wb_rd = 5'd0; wb_data = 32'hDEADBEEF;
        tick();
        wb_regwrite = 1'b0;
        #1 check("r0_wb_drop", regwrite, 0);
        md_issue = 1'b1; md_issue_rd = 5'd0;
        tick();
        md_issue = 1'b0;
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h12345678;
        #1;
        check("r0_md_ready", md_ready, 1);
        check("r0_haz", hazard_rs, 0);
        tick();
        md_valid = 1'b0;
        #1 check("r0_md_drop", regwrite, 0);
        tick();

        // Reset in WAIT with counter 2 and reg 3 pending
        md_issue = 1'b1; md_issue_rd = 5'd3;
        tick();
        md_issue = 1'b0;
        wb_regwrite = 1'b1; wb_rd = 5'd2; wb_data = 32'h00000222;
        md_valid = 1'b1; md_rd = 5'd3; md_data = 32'h33333333;
        dec_rs = 5'd3;
        tick();
        tick();
        #1;
        check("mid_cnt2", dbg_wait_cnt, 2);
        check("mid_wait", dbg_state, 1);
        check("mid_pend3", hazard_rs, 1);
        rst = 1'b1;
        tick();
        #1;
        check("mid_rst_cnt", dbg_wait_cnt, 0);
        check("mid_rst_pend", hazard_rs, 0);
        check("mid_rst_stall", stall_wb, 0);
        rst = 1'b0;
        quiet();
        tick();

        // Randomized traffic at several WB load levels
        for (int ph = 0; ph < 3; ph++) begin
            wb_pct = (ph == 0) ? 30 : (ph == 1) ? 70 : 97;
            for (int c = 0; c < 700; c++) begin
                rst = ($urandom_range(0, 249) == 0);
                if (m_stall) wb_regwrite = ($urandom_range(0, 7) == 0);
                else         wb_regwrite = ($urandom_range(0, 99) < wb_pct);
                wb_rd   = 5'($urandom_range(0, 15));
                wb_data = $urandom;
                if (!(md_valid && !m_xfer)) begin
                    md_valid = ($urandom_range(0, 2) != 0);
                    md_rd    = 5'($urandom_range(0, 15));
                    md_data  = $urandom;
                end
                md_issue    = ($urandom_range(0, 3) == 0);
                md_issue_rd = 5'($urandom_range(0, 15));
                dec_rs      = 5'($urandom_range(0, 15));
                dec_rt      = 5'($urandom_range(0, 15));
                tick();
            end
        end

        rst = 1'b0;
        quiet();
        repeat (3) tick();
        check("exp_q_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbitrates the register file's single write port between the WB pipeline stage and the multi-cycle multiply/divide unit (MDU). Tracks MDU destination registers still in flight so DECODE can detect read-after-write hazards. Bounds MDU starvation by requesting a one-cycle WB stall. Sits between the WB/MDU result paths and the register file's `regwrite`/`rd`/`writedata` inputs.

## Interface
- `STARVE_LIMIT`, 4: consecutive blocked cycles (1..15) after which `stall_wb` is raised.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `wb_regwrite` in 1: WB stage write request; cannot be back-pressured.
- `wb_rd` in 5: WB destination register.
- `wb_data` in 32: WB write data.
- `md_issue` in 1: MDU accepted an operation this cycle.
- `md_issue_rd` in 5: destination of the issued MDU operation.
- `md_valid` in 1: MDU result valid; held with `md_rd`/`md_data` stable until accepted.
- `md_ready` out 1: arbiter accepts the MDU result this cycle (combinational).
- `md_rd` in 5: MDU result destination.
- `md_data` in 32: MDU result data.
- `dec_rs` in 5: DECODE source register A.
- `dec_rt` in 5: DECODE source register B.
- `hazard_rs` out 1: `dec_rs` has a pending MDU write.
- `hazard_rt` out 1: `dec_rt` has a pending MDU write.
- `stall_wb` out 1: registered one-cycle request for the pipeline to insert a WB bubble.
- `regwrite` out 1: register file write enable (registered).
- `rd` out 5: register file write address (registered).
- `writedata` out 32: register file write data (registered).

## Operation
- Priority: WB always wins. `md_ready = md_valid & ~wb_regwrite & ~rst`.
- The MDU transfer occurs when `md_valid & md_ready`.
- Write-port selection each cycle:
  - If `wb_regwrite`: the WB request drives the port.
  - Else if the MDU transfer occurs: the MDU request drives the port.
  - Else: `regwrite` is 0 next cycle.
- Any write to register 0 is dropped: `regwrite` stays 0. A WB or MDU handshake to register 0 still completes normally.
- Scoreboard: 32-bit `pending` vector.
  - `md_issue` with `md_issue_rd != 0` sets `pending[md_issue_rd]`.
  - An MDU transfer clears `pending[md_rd]`.
  - If the set and the clear hit the same register in the same cycle, the set wins.
  - `pending[0]` is always 0.
- Hazard outputs (combinational from current state): `hazard_rs = pending[dec_rs]`, `hazard_rt = pending[dec_rt]`.
- Starvation FSM, with a wait counter of 4 bits:
  - IDLE: `md_valid` is 0. Counter is 0.
  - WAIT: `md_valid & ~md_ready`. The counter increments each such cycle. When the counter equals `STARVE_LIMIT-1` and the MDU is still blocked, go to FORCE; `stall_wb` is 1 next cycle.
  - FORCE: `stall_wb` is 1 for exactly one cycle, and the counter is reset to 0.
    - The pipeline guarantees `wb_regwrite` is 0 in this cycle, so the MDU transfer occurs.
    - If `wb_regwrite` is nonetheless 1, WB still wins and the FSM returns to WAIT with the counter at 0.
  - Any MDU transfer, or `md_valid` falling, returns the FSM to IDLE with the counter at 0.
- Reset state: `pending` = 0; `regwrite` = 0, `rd` = 0, `writedata` = 0; `stall_wb` = 0; FSM in IDLE, counter 0.
  - `md_ready` is 0 while `rst` is high.
  - Reset mid-operation discards any in-flight MDU handshake and all pending bits.

## Timing
- Write latency is 1 cycle: a request accepted in cycle N appears on `regwrite`/`rd`/`writedata` in cycle N+1. The register file commits it at the edge ending cycle N+1.
- `md_ready` and the hazard outputs are combinational, with no internal registered dependency on same-cycle inputs other than those listed.
- A scoreboard clear is visible on `hazard_*` starting cycle N+1 after a transfer in cycle N. This coincides with the registered write reaching the register file; DECODE re-reads the register after `hazard_*` drops.
- A set from `md_issue` in cycle N is visible in cycle N+1.
- Worst-case MDU wait while WB writes continuously: `STARVE_LIMIT` blocked cycles, plus 1 FORCE cycle.
- At most one write per cycle. Back-to-back writes from alternating sources carry no bubble.

## Test plan
- Reset:
  - Stimulus: hold `rst` 2 cycles with `md_valid`=1.
  - Response: `md_ready`=0, `regwrite`=0, `stall_wb`=0, `hazard_rs`=`hazard_rt`=0.
- Priority conflict:
  - Stimulus: cycle N, `wb_regwrite`=1, `wb_rd`=5, `wb_data`=0x11111111; `md_valid`=1, `md_rd`=6, `md_data`=0x22222222.
  - Response: `md_ready`=0 in N. N+1 writes reg 5. If WB is idle in N+1, `md_ready`=1 and N+2 writes reg 6 = 0x22222222.
- Starvation:
  - Stimulus: `wb_regwrite` held at 1 with `STARVE_LIMIT`=4, `md_valid`=1.
  - Response: `stall_wb`=1 in the 5th cycle only. With `wb_regwrite` dropped in that cycle, the MDU transfer occurs and the counter returns to 0.
- Scoreboard:
  - Stimulus: `md_issue` with rd=9. Set `dec_rs`=9, `dec_rt`=9. Later, the MDU transfer with `md_rd`=9.
  - Response: `hazard_rs`=`hazard_rt`=1 from the next cycle until the cycle after the transfer, then 0. A same-cycle issue and transfer to reg 9 leaves `pending[9]`=1.
- Register 0:
  - Stimulus: WB write to rd=0 with data 0xDEADBEEF; MDU issue and transfer to rd=0.
  - Response: `regwrite` never asserted; the MDU handshake completes; `hazard` for rs=0 stays 0.
- Reset mid-wait:
  - Stimulus: assert `rst` during WAIT with counter=2 and pending reg 3.
  - Response: next cycle the counter is 0, `pending[3]`=0, `stall_wb`=0.
